// File: rtl/word_serializer_if.sv
// Parallel-in / serial-out handshake bundle for word_serializer.
// master = word source + downstream observer, slave = the serializer.
interface word_serializer_if #(
   parameter int DATA_WID = 8
);
   logic [DATA_WID-1:0] in_data;
   logic                in_dir;
   logic                in_valid;
   logic                in_ready;
   logic                ser_data;
   logic                ser_dir;
   logic                ser_valid;
   logic                word_done;

   modport master (
      output in_data, in_dir, in_valid,
      input  in_ready, ser_data, ser_dir, ser_valid, word_done
   );

   modport slave (
      input  in_data, in_dir, in_valid,
      output in_ready, ser_data, ser_dir, ser_valid, word_done
   );
endinterface

// File: rtl/word_serializer.sv
// Serializes one parallel word per handshake, ordering bits so a downstream
// bidirectional shift register ends up holding the word after DATA_WID shifts.
module word_serializer #(
   parameter int DATA_WID = 8
) (
   input  logic             clk,
   input  logic             rst,
   word_serializer_if.slave bus
);
   localparam int CW = $clog2(DATA_WID);
   localparam logic [CW-1:0] LAST = CW'(DATA_WID - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state, state_d;
   logic [CW-1:0]       cnt, cnt_d;
   logic [DATA_WID-1:0] shadow, shadow_d, src;
   logic                sdata, sdata_d;
   logic                sdir, sdir_d;
   logic                svalid, svalid_d;
   logic                done, done_d;
   logic                dsel, last, accept;

   assign last         = (state == SHIFT) && (cnt == LAST);
   assign bus.in_ready = (state == IDLE) || last;
   assign accept       = bus.in_valid && bus.in_ready;

   // The next bit always sits at the end of the shadow word that faces the
   // direction of travel, so the word is consumed by plain shifts.
   assign src  = accept ? bus.in_data : shadow;
   assign dsel = accept ? bus.in_dir  : sdir;

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      shadow_d = shadow;
      sdata_d  = 1'b0;
      sdir_d   = sdir;
      svalid_d = 1'b0;
      done_d   = 1'b0;

      if (accept) begin
         state_d = SHIFT;
         cnt_d   = '0;
         sdir_d  = bus.in_dir;
      end else if ((state == SHIFT) && !last) begin
         cnt_d = cnt + 1'b1;
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
      end

      svalid_d = (state_d == SHIFT);
      if (svalid_d) begin
         if (dsel) begin
            sdata_d  = src[DATA_WID-1];
            shadow_d = {src[DATA_WID-2:0], 1'b0};
         end else begin
            sdata_d  = src[0];
            shadow_d = {1'b0, src[DATA_WID-1:1]};
         end
      end
      done_d = svalid_d && (cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         shadow <= '0;
         sdata  <= 1'b0;
         sdir   <= 1'b0;
         svalid <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         shadow <= shadow_d;
         sdata  <= sdata_d;
         sdir   <= sdir_d;
         svalid <= svalid_d;
         done   <= done_d;
      end
   end

   assign bus.ser_data  = sdata;
   assign bus.ser_dir   = sdir;
   assign bus.ser_valid = svalid;
   assign bus.word_done = done;
endmodule

// File: tb/tb_word_serializer.sv
// Randomized bench for word_serializer: a queue-of-bits reference model plus a
// downstream shift-register model that must reassemble every completed word.
module tb_word_serializer;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   word_serializer_if #(.DATA_WID(W)) bus();
   word_serializer #(.DATA_WID(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: every accepted word expands into W queued bit slots.
   typedef struct packed {
      logic b;
      logic dir;
      logic done;
   } slot_t;

   slot_t          q[$];
   logic [W-1:0]   words[$];
   logic           last_dir = 1'b0;
   bit             chk_en = 1'b0;

   // Downstream register model, fed from the DUT's own serial outputs.
   logic [W-1:0]   dreg = '0;
   logic [W-1:0]   cap = '0;
   logic [W-1:0]   done_reg = '0;
   logic [W-1:0]   done_exp = '0;
   logic           done_ok = 1'b0;
   int             done_seq = 0;
   int             seen_seq = 0;
   int             run = 0;
   int             last_run = 0;

   initial begin
      slot_t e;
      logic  acc;
      forever begin
         @(posedge clk);
         if (chk_en && bus.ser_valid === 1'b1) begin
            dreg = bus.ser_dir ? {dreg[W-2:0], bus.ser_data} : {bus.ser_data, dreg[W-1:1]};
            cap  = {cap[W-2:0], bus.ser_data};
            run++;
            if (bus.word_done === 1'b1) begin
               done_reg = dreg;
               done_ok  = (words.size() > 0);
               done_exp = done_ok ? words.pop_front() : '0;
               done_seq++;
            end
         end else begin
            if (run != 0) last_run = run;
            run = 0;
         end

         if (rst) begin
            q.delete();
            words.delete();
            last_dir = 1'b0;
         end else begin
            acc = bus.in_valid && (q.size() <= 1);
            if (q.size() > 0) begin
               last_dir = q[0].dir;
               void'(q.pop_front());
            end
            if (acc) begin
               words.push_back(bus.in_data);
               for (int i = 0; i < W; i++) begin
                  e.b    = bus.in_dir ? bus.in_data[W-1-i] : bus.in_data[i];
                  e.dir  = bus.in_dir;
                  e.done = (i == W - 1);
                  q.push_back(e);
               end
            end
         end
      end
   end

   // Per-cycle comparison of all outputs against the model.
   initial begin
      logic ev;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            ev = (q.size() > 0);
            check("ser_valid", 32'(bus.ser_valid), 32'(ev));
            check("in_ready", 32'(bus.in_ready), 32'(q.size() <= 1));
            check("ser_dir", 32'(bus.ser_dir), 32'(ev ? q[0].dir : last_dir));
            check("word_done", 32'(bus.word_done), 32'(ev && q[0].done));
            if (ev) check("ser_data", 32'(bus.ser_data), 32'(q[0].b));
            if (done_seq != seen_seq) begin
               seen_seq = done_seq;
               check("done_expected", 32'(done_ok), 32'd1);
               check("downstream_word", 32'(done_reg), 32'(done_exp));
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic dir, input bit hold);
      int n = 0;
      bus.in_data  = d;
      bus.in_dir   = dir;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stayed %0b, required 1", bus.in_ready);
      end
      @(negedge clk);
      if (!hold) begin
         bus.in_valid = 1'b0;
         bus.in_data  = W'($urandom);
         bus.in_dir   = 1'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: %0d bits pending, required 0", q.size());
      end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_dir   = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
      check("rst_ser_dir", 32'(bus.ser_dir), 32'd0);
      check("rst_ser_data", 32'(bus.ser_data), 32'd0);
      check("rst_word_done", 32'(bus.word_done), 32'd0);

      // A5 is bit-symmetric: both orders emit 1,0,1,0,0,1,0,1.
      send(8'hA5, 1'b1, 1'b0);
      wait_idle();
      check("t1_bits", 32'(cap), 32'h A5);
      check("t1_reg", 32'(dreg), 32'h A5);

      send(8'hA5, 1'b0, 1'b0);
      wait_idle();
      check("t2_bits", 32'(cap), 32'h A5);
      check("t2_reg", 32'(dreg), 32'h A5);

      send(8'h3C, 1'b1, 1'b1);
      send(8'hC3, 1'b0, 1'b0);
      wait_idle();
      check("t3_run", 32'(last_run), 32'd16);
      check("t3_reg", 32'(dreg), 32'h C3);

      send(8'h00, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      bus.in_data  = 8'hFF;
      bus.in_dir   = 1'b0;
      bus.in_valid = 1'b1;
      check("t4_busy", 32'(bus.in_ready), 32'd0);
      send(8'hFF, 1'b0, 1'b0);
      wait_idle();
      check("t4_reg", 32'(dreg), 32'h FF);

      send(8'h5A, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_valid", 32'(bus.ser_valid), 32'd0);
      check("t5_ready", 32'(bus.in_ready), 32'd1);
      check("t5_done", 32'(bus.word_done), 32'd0);
      send(8'h81, 1'b1, 1'b0);
      wait_idle();
      check("t5_bits", 32'(cap), 32'h 81);
      check("t5_reg", 32'(dreg), 32'h 81);

      repeat (20) begin
         @(negedge clk);
         check("t6_dir_hold", 32'(bus.ser_dir), 32'd1);
         check("t6_ready", 32'(bus.in_ready), 32'd1);
      end

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            send(W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            if (bus.in_valid == 1'b0) repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
